// File: rtl/pipeline_join_masked_if.sv
// Handshake bundle for pipeline_join_masked: per-lane input streams plus the
// single joined output stream. The join block sits on the slave modport.
interface pipeline_join_masked_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 4
);
  localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT;

  logic [INPUT_COUNT-1:0] input_valid;
  logic [INPUT_COUNT-1:0] input_ready;
  logic [TOTAL_WIDTH-1:0] input_data;
  logic                   output_valid;
  logic                   output_ready;
  logic [TOTAL_WIDTH-1:0] output_data;
  logic [INPUT_COUNT-1:0] output_mask;

  modport slave (
    input  input_valid,
    input  input_data,
    output input_ready,
    output output_valid,
    output output_data,
    output output_mask,
    input  output_ready
  );

  modport master (
    output input_valid,
    output input_data,
    input  input_ready,
    input  output_valid,
    input  output_data,
    input  output_mask,
    output output_ready
  );
endinterface

// File: rtl/pipeline_join_masked.sv
// Masked N-way join: one FIFO per lane, a registered runtime lane mask and a
// registered output word that carries every enabled lane's head together.
module pipeline_join_masked #(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 4,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [INPUT_COUNT-1:0] lane_mask,
  input  logic [INPUT_COUNT-1:0] lane_flush,
  pipeline_join_masked_if.slave  bus,
  output logic [COUNT_WIDTH-1:0] join_count
);

  localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                   run_q;
  logic [INPUT_COUNT-1:0] mask_q;
  logic [INPUT_COUNT-1:0] lane_ready;
  logic [INPUT_COUNT-1:0] lane_push;
  logic [INPUT_COUNT-1:0] lane_pop;
  logic [INPUT_COUNT-1:0] lane_avail;
  logic [TOTAL_WIDTH-1:0] join_data;
  logic                   fire;

  logic                   vld_p1;
  logic [TOTAL_WIDTH-1:0] data_p1;
  logic [INPUT_COUNT-1:0] mask_p1;
  logic [COUNT_WIDTH-1:0] join_count_q;

  // Stage p0: mask capture; run_q holds input_ready low until the first edge after clear
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      run_q  <= 1'b0;
      mask_q <= '0;
    end else begin
      run_q  <= 1'b1;
      mask_q <= lane_mask;
    end
  end

  // Stage p0: per-lane FIFOs
  for (genvar j = 0; j < INPUT_COUNT; j++) begin : g_lane
    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    // Ready looks only at registered occupancy, so a full FIFO refuses a push
    // even in a cycle where it also pops.
    assign lane_ready[j] = run_q & (count < FULL_CNT);
    assign lane_push[j]  = bus.input_valid[j] & lane_ready[j] & ~lane_flush[j];
    assign lane_avail[j] = ~mask_q[j] | ((count != '0) & ~lane_flush[j]);
    assign lane_pop[j]   = fire & mask_q[j];
    assign join_data[WORD_WIDTH*j +: WORD_WIDTH] = mask_q[j] ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (lane_flush[j]) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (lane_push[j]) wr_ptr <= wr_ptr + 1'b1;
        if (lane_pop[j])  rd_ptr <= rd_ptr + 1'b1;
        case ({lane_push[j], lane_pop[j]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (lane_push[j]) mem[wr_ptr] <= bus.input_data[WORD_WIDTH*j +: WORD_WIDTH];
    end
  end

  // Masked-off lanes count as available; an all-zero mask never fires.
  assign fire = (|mask_q) & (&lane_avail) & (~vld_p1 | bus.output_ready);

  // Stage p1: output register and completed-join counter
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      mask_p1      <= '0;
      join_count_q <= '0;
    end else begin
      if (fire) begin
        vld_p1  <= 1'b1;
        data_p1 <= join_data;
        mask_p1 <= mask_q;
      end else if (bus.output_ready) begin
        vld_p1  <= 1'b0;
      end
      if (vld_p1 & bus.output_ready) join_count_q <= join_count_q + 1'b1;
    end
  end

  assign bus.input_ready  = lane_ready;
  assign bus.output_valid = vld_p1;
  assign bus.output_data  = data_p1;
  assign bus.output_mask  = mask_p1;
  assign join_count       = join_count_q;

endmodule

// File: doc/pipeline_join_masked.md
Name: pipeline_join_masked

Overview:
- Successor to the fixed N-way pipeline join.
- Accepts INPUT_COUNT ready/valid input streams, each into its own DEPTH-entry FIFO.
- Whenever every lane enabled by a runtime mask holds a word, it emits one joined word through a registered output stage.
- Adds per-lane depth, runtime lane masking, per-lane flush and a completed-join counter. Used where some producers are optionally absent or run bursty relative to each other.

Parameters:
- WORD_WIDTH, 8, bits per lane word.
- INPUT_COUNT, 4, number of input lanes (>=1).
- DEPTH, 4, entries per lane FIFO; power of two, >=2.
- COUNT_WIDTH, 16, width of join_count.
- TOTAL_WIDTH, WORD_WIDTH*INPUT_COUNT, derived; not set at instantiation.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- clear  in  1  asynchronous active-high reset.
- lane_mask  in  INPUT_COUNT  1 = lane participates in joins; quasi-static.
- lane_flush  in  INPUT_COUNT  synchronous pulse; empties that lane's FIFO.
- input_valid  in  INPUT_COUNT  per-lane valid.
- input_ready  out  INPUT_COUNT  per-lane ready.
- input_data  in  TOTAL_WIDTH  lane j at [WORD_WIDTH*j +: WORD_WIDTH].
- output_valid  out  1  joined word valid.
- output_ready  in  1  downstream ready.
- output_data  out  TOTAL_WIDTH  joined data; masked-off lanes are zero.
- output_mask  out  INPUT_COUNT  mask_q value used for the word currently presented.
- join_count  out  COUNT_WIDTH  completed output handshakes; wraps.

Behaviour:
- Reset (clear high, asynchronous, takes effect immediately):
  - all FIFOs empty; input_ready all 0 while clear is asserted, then 1 from the first cycle after release.
  - output_valid=0, output_data=0, output_mask=0, join_count=0, mask_q=0.
- Mask register:
  - mask_q <= lane_mask every cycle; joins use mask_q only (1 cycle mask latency).
  - Because mask_q=0 the cycle after reset, no join can fire in that cycle.
- Per-lane FIFO:
  - input_ready[j] = (count_j < DEPTH); registered state only, with no combinational path from any valid or output_ready.
  - Push when input_valid[j] & input_ready[j]. A full FIFO refuses the push even if it pops in the same cycle.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally; count_j is log2(DEPTH)+1 bits.
- Masked-off lanes:
  - FIFO still accepts words up to DEPTH and holds them; they are not popped.
  - When the lane is re-enabled, its held words join in FIFO order.
- Join condition: fire = (mask_q != 0) & (every lane with mask_q[j]=1 has count_j>0) & (~output_valid | output_ready).
- On fire:
  - pop the head of every enabled lane.
  - output_data lane j <= head_j if mask_q[j], else 0.
  - output_mask <= mask_q; output_valid <= 1.
- Output register:
  - If output_valid & output_ready & ~fire: output_valid <= 0 and data holds its last value.
  - output_data and output_mask are stable while output_valid & ~output_ready.
- Latency: a word pushed at edge t into an empty FIFO, with all other enabled lanes non-empty, is visible at output_valid after edge t+1. Throughput is one join per cycle with output_ready held high.
- join_count increments on each output_valid & output_ready; it wraps from 2^COUNT_WIDTH-1 to 0.
- lane_flush[j]: at the next edge count_j=0 and both pointers reset to 0.
  - A push in the same cycle is discarded.
  - A pop in the same cycle is suppressed, so no fire uses lane j that cycle: lane j is treated as empty for that cycle's fire evaluation.
  - Flush does not affect a word already in the output register.
- mask_q all zero: no joins; output stage still drains its pending word normally.
- Mask change while output_valid & ~output_ready: the presented word and its output_mask are unchanged; the new mask applies to the next fire.

Test Plan:
- Reset then 4 lanes all enabled; push 0x11,0x22,0x33,0x44 in one cycle, output_ready=1 -> output_valid two edges later with output_data=0x44332211; join_count=1.
- lane_mask=4'b0101; push lanes 0,2 only with 0xAA,0xBB -> output_data=0x00BB00AA, output_mask=0101; lanes 1,3 FIFOs untouched.
- output_ready=0; stream lane 0 continuously with other lanes empty -> lane 0 accepts exactly DEPTH=4 words, then input_ready[0]=0 with no output; release -> words emerge in order.
- All lanes fed every cycle, output_ready=1 for 20 cycles -> 20 consecutive joins with no bubbles after the first; then toggle output_ready 1-0 -> data held stable while stalled.
- Pulse lane_flush[1] with lane 1 holding 3 words while lane 0 pushes -> lane 1 count 0 and input_ready[1]=1 next cycle; no join until lane 1 receives new data.
- Assert clear asynchronously between edges with output_valid=1 -> output_valid, join_count and all counts 0 immediately; join_count wrap checked with COUNT_WIDTH=2 (four handshakes -> 0).
